// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues in-order imem reads and
// buffers returned words for decode, discarding responses made stale by a redirect.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [AW-1:0] ONE_A = AW'(1);
    localparam logic [CW:0]   CAP   = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [AW-1:0] pend_wr, pend_rd;
    logic [AW-1:0] q_wr, q_rd;
    logic [31:0]   pend_pc [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_data  [DEPTH];

    logic [CW:0] credit_used;
    logic        req_fire;
    logic        resp_drop;
    logic        resp_keep;
    logic        pop;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    // Credits cover both buffered entries and outstanding reads, so the queue can never overflow.
    assign credit_used    = {1'b0, in_flight} + {1'b0, q_count};
    assign imem_req_valid = rst_n & en & ~redirect_valid & (credit_used < CAP);
    assign imem_req_addr  = fetch_pc;

    assign req_fire  = imem_req_valid & imem_req_ready;
    assign resp_drop = imem_resp_valid & (redirect_valid | (drop_cnt != '0));
    assign resp_keep = imem_resp_valid & ~resp_drop;
    assign inst_valid = (q_count != '0);
    assign pop        = inst_valid & inst_ready;

    assign inst_data = inst_valid ? q_data[q_rd] : '0;
    assign inst_pc   = inst_valid ? q_pc[q_rd]   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            if (redirect_valid)
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;

            unique case ({req_fire, imem_resp_valid})
                2'b10:   in_flight <= in_flight + ONE_C;
                2'b01:   in_flight <= in_flight - ONE_C;
                default: in_flight <= in_flight;
            endcase

            // in_flight already includes reads marked for dropping, so it alone is the new drop count.
            if (redirect_valid)
                drop_cnt <= imem_resp_valid ? (in_flight - ONE_C) : in_flight;
            else if (resp_drop)
                drop_cnt <= drop_cnt - ONE_C;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_wr <= '0;
            pend_rd <= '0;
            q_wr    <= '0;
            q_rd    <= '0;
            q_count <= '0;
        end else if (redirect_valid) begin
            pend_wr <= '0;
            pend_rd <= '0;
            q_wr    <= '0;
            q_rd    <= '0;
            q_count <= '0;
        end else begin
            if (req_fire)
                pend_wr <= pend_wr + ONE_A;
            if (resp_keep) begin
                pend_rd <= pend_rd + ONE_A;
                q_wr    <= q_wr + ONE_A;
            end
            if (pop)
                q_rd <= q_rd + ONE_A;

            unique case ({resp_keep, pop})
                2'b10:   q_count <= q_count + ONE_C;
                2'b01:   q_count <= q_count - ONE_C;
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            pend_pc[pend_wr] <= fetch_pc;
        if (resp_keep) begin
            q_pc[q_wr]   <= pend_pc[pend_rd];
            q_data[q_wr] <= imem_resp_data;
        end
    end

    resp_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) imem_resp_valid |-> (in_flight != '0)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order, fixed-latency memory model.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    localparam logic [31:0] DMASK = 32'hDEAD_BEEF;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mon_cyc  = 0;
    int mem_lat  = 1;

    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] acc_log [$];
    logic [31:0] pop_log [$];
    logic [31:0] pop_dat [$];
    int          pop_cyc [$];

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    // Memory returns addr^DMASK, in order, mem_lat cycles after each accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else begin
            if (imem_resp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + mem_lat);
                acc_log.push_back(imem_req_addr);
            end
            cyc++;
            #1;
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mq_addr[0] ^ DMASK;
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    always @(posedge clk) begin
        mon_cyc++;
        if (rst_n === 1'b1 && inst_valid && inst_ready) begin
            pop_log.push_back(inst_pc);
            pop_dat.push_back(inst_data);
            pop_cyc.push_back(mon_cyc);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        mem_lat = 1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        step(2);
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_req_addr got=%h exp=00000000", imem_req_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_inst_valid got=%b exp=0", inst_valid); end
        checks++; if (inst_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst_data got=%h exp=00000000", inst_data); end
        checks++; if (inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst_pc got=%h exp=00000000", inst_pc); end
    endtask

    task automatic test_stream();
        int bp, ba;
        logic [31:0] exp_pc;
        do_reset();
        bp = pop_log.size();
        ba = acc_log.size();
        en = 1'b1;
        step(10);
        checks++; if (pop_log.size() < bp + 6) begin failures++; $display("[TB] FAIL stream_pop_count got=%0d exp>=6", pop_log.size() - bp); end
        for (int k = 0; k < 6; k++) begin
            exp_pc = 32'(4 * k);
            checks++; if (acc_log[ba+k] !== exp_pc) begin failures++; $display("[TB] FAIL stream_addr%0d got=%h exp=%h", k, acc_log[ba+k], exp_pc); end
            checks++; if (pop_log[bp+k] !== exp_pc) begin failures++; $display("[TB] FAIL stream_pc%0d got=%h exp=%h", k, pop_log[bp+k], exp_pc); end
            checks++; if (pop_dat[bp+k] !== (exp_pc ^ DMASK)) begin failures++; $display("[TB] FAIL stream_data%0d got=%h exp=%h", k, pop_dat[bp+k], exp_pc ^ DMASK); end
        end
        checks++; if (pop_cyc[bp+5] - pop_cyc[bp] !== 5) begin failures++; $display("[TB] FAIL stream_rate got=%0d cycles exp=5", pop_cyc[bp+5] - pop_cyc[bp]); end
    endtask

    task automatic test_en_hold();
        int ba, n0;
        do_reset();
        ba = acc_log.size();
        en = 1'b1;
        step(6);
        en = 1'b0;
        n0 = acc_log.size();
        checks++; if (n0 - ba !== 6) begin failures++; $display("[TB] FAIL hold_accepts got=%0d exp=6", n0 - ba); end
        step(5);
        checks++; if (acc_log.size() !== n0) begin failures++; $display("[TB] FAIL hold_no_req got=%0d exp=%0d", acc_log.size(), n0); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h18) begin failures++; $display("[TB] FAIL hold_addr got=%h exp=00000018", imem_req_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_drained got=%b exp=0", inst_valid); end
        imem_req_ready = 1'b0;
        en = 1'b1;
        step(3);
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_req_valid got=%b exp=1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h18) begin failures++; $display("[TB] FAIL stall_addr got=%h exp=00000018", imem_req_addr); end
        imem_req_ready = 1'b1;
        step(1);
        checks++; if (acc_log[n0] !== 32'h18) begin failures++; $display("[TB] FAIL resume_addr got=%h exp=00000018", acc_log[n0]); end
        checks++; if (imem_req_addr !== 32'h1C) begin failures++; $display("[TB] FAIL resume_next got=%h exp=0000001c", imem_req_addr); end
    endtask

    task automatic test_backpressure();
        int bp, ba;
        logic [31:0] exp_pc;
        do_reset();
        inst_ready = 1'b0;
        bp = pop_log.size();
        ba = acc_log.size();
        en = 1'b1;
        step(10);
        checks++; if (acc_log.size() - ba !== 4) begin failures++; $display("[TB] FAIL bp_accepts got=%0d exp=4", acc_log.size() - ba); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL bp_head got=%b/%h exp=1/00000000", inst_valid, inst_pc); end
        step(3);
        checks++; if (inst_pc !== 32'h0 || inst_data !== DMASK) begin failures++; $display("[TB] FAIL bp_stable got=%h/%h exp=00000000/%h", inst_pc, inst_data, DMASK); end
        inst_ready = 1'b1;
        step(8);
        for (int k = 0; k < 5; k++) begin
            exp_pc = 32'(4 * k);
            checks++; if (pop_log[bp+k] !== exp_pc) begin failures++; $display("[TB] FAIL bp_drain%0d got=%h exp=%h", k, pop_log[bp+k], exp_pc); end
        end
        checks++; if (acc_log[ba+4] !== 32'h10) begin failures++; $display("[TB] FAIL bp_resume got=%h exp=00000010", acc_log[ba+4]); end
    endtask

    task automatic test_redirect_drop();
        int bp, ba;
        do_reset();
        mem_lat = 3;
        bp = pop_log.size();
        ba = acc_log.size();
        en = 1'b1;
        step(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rd_req_blocked got=%b exp=0", imem_req_valid); end
        step(1);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_addr !== 32'h100 || imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd_next_addr got=%b/%h exp=1/00000100", imem_req_valid, imem_req_addr); end
        step(12);
        checks++; if (acc_log[ba+2] !== 32'h100) begin failures++; $display("[TB] FAIL rd_acc got=%h exp=00000100", acc_log[ba+2]); end
        checks++; if (pop_log[bp] !== 32'h100) begin failures++; $display("[TB] FAIL rd_first_pc got=%h exp=00000100", pop_log[bp]); end
        checks++; if (pop_log[bp+1] !== 32'h104) begin failures++; $display("[TB] FAIL rd_second_pc got=%h exp=00000104", pop_log[bp+1]); end
        checks++; if (pop_dat[bp] !== (32'h100 ^ DMASK)) begin failures++; $display("[TB] FAIL rd_first_data got=%h exp=%h", pop_dat[bp], 32'h100 ^ DMASK); end
    endtask

    task automatic test_redirect_pop();
        int bp;
        do_reset();
        inst_ready = 1'b0;
        en = 1'b1;
        step(8);
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL rp_filled got=%b exp=1", inst_valid); end
        bp = pop_log.size();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step(1);
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL rp_cleared got=%b exp=0", inst_valid); end
        step(6);
        checks++; if (pop_log[bp] !== 32'h0) begin failures++; $display("[TB] FAIL rp_delivered got=%h exp=00000000", pop_log[bp]); end
        checks++; if (pop_log[bp+1] !== 32'h200) begin failures++; $display("[TB] FAIL rp_after got=%h exp=00000200", pop_log[bp+1]); end
        checks++; if (pop_log[bp+2] !== 32'h204) begin failures++; $display("[TB] FAIL rp_after2 got=%h exp=00000204", pop_log[bp+2]); end
    endtask

    task automatic test_wrap();
        int bp, ba;
        do_reset();
        en = 1'b1;
        step(5);
        ba = acc_log.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step(1);
        redirect_valid = 1'b0;
        bp = pop_log.size();
        checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_align got=%h exp=fffffffc", imem_req_addr); end
        step(8);
        checks++; if (acc_log[ba] !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_acc0 got=%h exp=fffffffc", acc_log[ba]); end
        checks++; if (acc_log[ba+1] !== 32'h0) begin failures++; $display("[TB] FAIL wrap_acc1 got=%h exp=00000000", acc_log[ba+1]); end
        checks++; if (pop_log[bp] !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_pop0 got=%h exp=fffffffc", pop_log[bp]); end
        checks++; if (pop_log[bp+1] !== 32'h0) begin failures++; $display("[TB] FAIL wrap_pop1 got=%h exp=00000000", pop_log[bp+1]); end
        checks++; if (pop_dat[bp] !== (32'hFFFF_FFFC ^ DMASK)) begin failures++; $display("[TB] FAIL wrap_data got=%h exp=%h", pop_dat[bp], 32'hFFFF_FFFC ^ DMASK); end
    endtask

    task automatic test_back_to_back();
        int bp, ba;
        do_reset();
        mem_lat = 3;
        bp = pop_log.size();
        ba = acc_log.size();
        en = 1'b1;
        step(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        step(1);
        redirect_pc = 32'h400;
        step(1);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_addr !== 32'h400) begin failures++; $display("[TB] FAIL b2b_addr got=%h exp=00000400", imem_req_addr); end
        step(12);
        checks++; if (acc_log[ba+2] !== 32'h400) begin failures++; $display("[TB] FAIL b2b_acc got=%h exp=00000400", acc_log[ba+2]); end
        checks++; if (pop_log[bp] !== 32'h400) begin failures++; $display("[TB] FAIL b2b_pop0 got=%h exp=00000400", pop_log[bp]); end
        checks++; if (pop_log[bp+1] !== 32'h404) begin failures++; $display("[TB] FAIL b2b_pop1 got=%h exp=00000404", pop_log[bp+1]); end
    endtask

    task automatic test_reset_mid();
        int ba;
        do_reset();
        inst_ready = 1'b0;
        en = 1'b1;
        step(4);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL rm_setup got=%b/%h exp=1/00000000", inst_valid, inst_pc); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_inst_valid got=%b exp=0", inst_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL rm_req_addr got=%h exp=00000000", imem_req_addr); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_req_valid got=%b exp=0", imem_req_valid); end
        en = 1'b0;
        step(2);
        rst_n = 1'b1;
        ba = acc_log.size();
        for (int k = 0; k < 4; k++) begin
            step(1);
            checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_idle%0d got=%b exp=0", k, imem_req_valid); end
        end
        checks++; if (acc_log.size() !== ba || inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_quiet got=%0d/%b exp=0/0", acc_log.size() - ba, inst_valid); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_stream();
        test_en_hold();
        test_backpressure();
        test_redirect_drop();
        test_redirect_pop();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
